// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multicycle signed multiply/divide unit.
package mult_div_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH);
  localparam int ITER      = DEF_WIDTH;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Two's complement negate (mod 2^WIDTH) when s is set.
  function automatic logic [DEF_WIDTH-1:0] cond_neg(input logic [DEF_WIDTH-1:0] v,
                                                    input logic s);
    cond_neg = s ? ({DEF_WIDTH{1'b0}} - v) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division iteration on a {remainder, dividend} shift register.
module mult_div_unit_div_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] rem_dvd,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] rem_dvd_next,
  output logic               q_bit
);

  logic [WIDTH:0] partial_s;
  logic [WIDTH:0] diff_s;

  assign partial_s = rem_dvd[2*WIDTH-1:WIDTH-1];
  assign diff_s    = partial_s - {1'b0, divisor};

  // Keep the trial subtraction only when it does not go negative.
  always_comb begin
    q_bit        = 1'b0;
    rem_dvd_next = {rem_dvd[2*WIDTH-2:0], 1'b0};
    if (diff_s[WIDTH] == 1'b0) begin
      q_bit        = 1'b1;
      rem_dvd_next = {diff_s[WIDTH-1:0], rem_dvd[WIDTH-2:0], 1'b1};
    end else begin
      q_bit        = 1'b0;
      rem_dvd_next = {partial_s[WIDTH-1:0], rem_dvd[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV unit: Booth multiply, restoring divide, HI/LO results.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start_mult,
  input  logic             start_div,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH+1:0]   booth_r;   // {acc (W+1), multiplier (W), q-1}
  logic [WIDTH:0]       mcand_r;
  logic [2*WIDTH-1:0]   rd_r;
  logic [WIDTH-1:0]     dvsr_r;
  logic                 sign_q_r;
  logic                 sign_r_r;
  logic                 is_div_r;

  logic [WIDTH:0]       booth_sum_s;
  logic [2*WIDTH+1:0]   booth_next_s;
  logic [2*WIDTH-1:0]   rd_next_s;
  logic                 q_bit_s;

  // Booth add/subtract selection; the accumulator carries one guard bit so -2^31 negates cleanly.
  always_comb begin
    booth_sum_s = booth_r[2*WIDTH+1:WIDTH+1];
    case (booth_r[1:0])
      2'b01:   booth_sum_s = booth_r[2*WIDTH+1:WIDTH+1] + mcand_r;
      2'b10:   booth_sum_s = booth_r[2*WIDTH+1:WIDTH+1] - mcand_r;
      default: booth_sum_s = booth_r[2*WIDTH+1:WIDTH+1];
    endcase
  end

  assign booth_next_s = {booth_sum_s[WIDTH], booth_sum_s, booth_r[WIDTH:1]};

  mult_div_unit_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_dvd      (rd_r),
    .divisor      (dvsr_r),
    .rem_dvd_next (rd_next_s),
    .q_bit        (q_bit_s)
  );

  // Control FSM, iteration datapath and registered HI/LO/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      booth_r  <= {(2*WIDTH+2){1'b0}};
      mcand_r  <= {(WIDTH+1){1'b0}};
      rd_r     <= {(2*WIDTH){1'b0}};
      dvsr_r   <= {WIDTH{1'b0}};
      sign_q_r <= 1'b0;
      sign_r_r <= 1'b0;
      is_div_r <= 1'b0;
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_mult) begin
            mcand_r  <= {a[WIDTH-1], a};
            booth_r  <= {{(WIDTH+1){1'b0}}, b, 1'b0};
            cnt_r    <= {CNT_W{1'b0}};
            is_div_r <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            state_r  <= MULT;
          end else if (start_div) begin
            busy <= 1'b1;
            if (b == {WIDTH{1'b0}}) begin
              div_zero <= 1'b1;
              done     <= 1'b1;
              state_r  <= DONE;
            end else begin
              rd_r     <= {{WIDTH{1'b0}}, cond_neg(a, a[WIDTH-1])};
              dvsr_r   <= cond_neg(b, b[WIDTH-1]);
              sign_q_r <= a[WIDTH-1] ^ b[WIDTH-1];
              sign_r_r <= a[WIDTH-1];
              cnt_r    <= {CNT_W{1'b0}};
              is_div_r <= 1'b1;
              div_zero <= 1'b0;
              state_r  <= DIV;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        MULT: begin
          booth_r <= booth_next_s;
          cnt_r   <= cnt_r + 1'b1;
          if (cnt_r == CNT_W'(ITER - 1)) state_r <= FIX;
        end
        DIV: begin
          rd_r  <= rd_next_s;
          cnt_r <= cnt_r + 1'b1;
          if (cnt_r == CNT_W'(ITER - 1)) state_r <= FIX;
        end
        FIX: begin
          if (is_div_r) begin
            lo <= cond_neg(rd_r[WIDTH-1:0], sign_q_r);
            hi <= cond_neg(rd_r[2*WIDTH-1:WIDTH], sign_r_r);
          end else begin
            {hi, lo} <= booth_r[2*WIDTH:1];
          end
          done    <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench: vector table through a done-driven scoreboard plus timing corner sequences.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic        start_mult, start_div;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .start_mult(start_mult), .start_div(start_div),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        is_div;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got done=1 expected no pulse at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("sb_hi", hi, e.hi);
        chk("sb_lo", lo, e.lo);
        chk("sb_div_zero", {31'd0, div_zero}, {31'd0, e.dz});
      end
    end
  end

  task automatic wait_idle(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) chk({name, "_done_timeout"}, 32'd0, 32'd1);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (!busy) got = 1'b1;
    end
    if (!got) chk({name, "_busy_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic is_div,
                       input exp_t e);
    @(negedge clk);
    a = va;
    b = vb;
    start_mult = !is_div;
    start_div  = is_div;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  vec_t tbl[12];

  initial begin
    int dc;
    tbl[0]  = '{32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    tbl[1]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0};
    tbl[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0000_0001, 1'b0};
    tbl[3]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000, 1'b0};
    tbl[4]  = '{32'h1234_5678, 32'h0000_0010, 1'b0, 32'h0000_0001, 32'h2345_6780, 1'b0};
    tbl[5]  = '{32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[6]  = '{32'h0000_0064, 32'hFFFF_FFF9, 1'b1, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0};
    tbl[7]  = '{32'hFFFF_FF9C, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0};
    tbl[8]  = '{32'h8000_0000, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 32'hEDB6_DB6E, 1'b0};
    tbl[9]  = '{32'h0000_0000, 32'h0000_0005, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[10] = '{32'h0000_0007, 32'h0000_0003, 1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0};
    tbl[11] = '{32'h0000_0005, 32'h0000_0000, 1'b1, 32'h0000_0001, 32'h0000_0002, 1'b1};

    reset = 1'b0;
    a = 32'd0;
    b = 32'd0;
    start_mult = 1'b0;
    start_div  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].is_div, '{tbl[i].hi, tbl[i].lo, tbl[i].dz});
      wait_idle($sformatf("vec%0d", i));
    end

    // Latency profile of a MULT started at E0.
    issue(32'd7, 32'hFFFF_FFFD, 1'b0, '{32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
    chk("lat_busy_e0", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("lat_busy_e%0d", k), {31'd0, busy}, {31'd0, (k <= 33)});
      chk($sformatf("lat_done_e%0d", k), {31'd0, done}, {31'd0, (k == 33)});
    end

    // Back-to-back: start at E34 ignored, start at E35 accepted.
    issue(32'd2, 32'd3, 1'b0, '{32'd0, 32'd6, 1'b0});
    repeat (33) @(posedge clk);
    #1;
    a = 32'd5;
    b = 32'd5;
    start_mult = 1'b1;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    chk("b2b_busy_e34", {31'd0, busy}, 32'd0);
    issue(32'd4, 32'd5, 1'b0, '{32'd0, 32'd20, 1'b0});
    chk("b2b_busy_e35", {31'd0, busy}, 32'd1);
    wait_idle("b2b");

    // Divide by zero: prior hi=1, lo=2, done in the cycle after E0.
    issue(32'd7, 32'd3, 1'b1, '{32'd1, 32'd2, 1'b0});
    wait_idle("dz_prep");
    issue(32'd5, 32'd0, 1'b1, '{32'd1, 32'd2, 1'b1});
    chk("dz_done_e0", {31'd0, done}, 32'd1);
    chk("dz_flag_e0", {31'd0, div_zero}, 32'd1);
    @(posedge clk);
    #1;
    chk("dz_idle_e1", {30'd0, busy, done}, 32'd0);
    chk("dz_held", {31'd0, div_zero}, 32'd1);
    issue(32'd3, 32'd4, 1'b0, '{32'd0, 32'd12, 1'b0});
    chk("dz_cleared", {31'd0, div_zero}, 32'd0);
    wait_idle("dz_after");

    // -2^31 / -1 with an ignored start_mult at E5.
    dc = done_cnt;
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, '{32'd0, 32'h8000_0000, 1'b0});
    repeat (4) @(posedge clk);
    #1;
    a = 32'd9;
    b = 32'd9;
    start_mult = 1'b1;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    wait_idle("ovf");
    repeat (45) @(posedge clk);
    chk("ovf_single_done", done_cnt - dc, 32'd1);

    // Reset mid-MULT at E10.
    dc = done_cnt;
    issue(32'd11, 32'd13, 1'b0, '{32'd0, 32'd143, 1'b0});
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mrst_hi", hi, 32'd0);
    chk("mrst_lo", lo, 32'd0);
    chk("mrst_flags", {30'd0, busy, done}, 32'd0);
    sb.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    chk("mrst_no_done", done_cnt - dc, 32'd0);
    issue(32'd3, 32'd4, 1'b0, '{32'd0, 32'd12, 1'b0});
    wait_idle("mrst_after");

    repeat (2) @(posedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
